text_grid_renderer: RTL
=======================

Name: text_grid_renderer

Overview:
Parametrised successor of the fixed 80x30 text renderer.
- Walks a LINES x COLUMNS character grid held in text RAM, one line word at a time.
- Shades every glyph row from the font ROM, with per-cell fg/bg, invert and blink attributes and a hardware cursor overlay (underline or block, blinkable).
- Writes each shaded glyph row to the back half of a double-buffered SRAM framebuffer through a valid/ready write port.
- Swaps buffers with the VGA scanner once per frame.

Parameters:
COLUMNS, 80, characters per line
LINES, 30, character lines per screen
CHAR_W, 8, glyph width in pixels (= font_data bits)
CHAR_H, 16, glyph height in rows
COLOR_W, 3, colour index bits per pixel
ADDR_W, 20, SRAM word address width
BUF_A, 0, word base address of buffer A
BUF_B, 'h40000, word base address of buffer B
BLINK_SHIFT, 4, blink phase = frame_cnt[BLINK_SHIFT]

Ports:
clk  in  1  clock
rst  in  1  reset
paint_done  in  1  scanner finished a full frame of vga_base
text_addr  out  clog2(LINES)  text RAM line address
text_data  in  COLUMNS*CELL_W  line word, valid 1 cycle after text_addr
font_addr  out  8+clog2(CHAR_H)  {char code, glyph row}
font_data  in  CHAR_W  glyph row, valid 1 cycle after font_addr
cursor_en  in  1  cursor enabled
cursor_blink  in  1  cursor blinks with blink phase
cursor_block  in  1  1 = block, 0 = underline (last two rows)
cursor_col  in  clog2(COLUMNS)  cursor column
cursor_line  in  clog2(LINES)  cursor line
px_valid  out  1  write request
px_ready  in  1  SRAM arbiter accepts
px_addr  out  ADDR_W  word address
px_data  out  CHAR_W*COLOR_W  one shaded glyph row
vga_base  out  ADDR_W  front buffer base
busy  out  1  frame render in progress
frame_cnt  out  8  completed swaps, wraps

Behaviour:
Clocking and reset:
- One clock clk; reset rst is synchronous, active-high.
- Reset values: state=FETCH, line=col=row=0, front=A (vga_base=BUF_A, back=BUF_B), px_valid=0, text_addr=0, font_addr=0, busy=0, frame_cnt=0, paint_pending=0.
- Reset mid-frame abandons the frame. No further px_valid is asserted until the next FETCH.

Cell format (CELL_W=8+2*COLOR_W+2): [7:0] code, fg, bg, invert, blink (LSB upward).

States:
- FETCH: drive text_addr=line. At line 0, snapshot the cursor inputs for the whole frame and set busy=1. Next: LATCH.
- LATCH: capture text_data into a line register. Next: FREQ.
- FREQ: font_addr={code[col],row}. Next: FWAIT.
- FWAIT: capture font_data, shade it, load px_addr and px_data, set px_valid=1. Next: EMIT.
- EMIT: hold px_valid and all px fields stable until px_ready.
  - On acceptance, advance row; then col; then line.
  - Go to FREQ within a line, FETCH at a new line, DONE after the last word.
- DONE: busy=0. If paint_pending is set: toggle front, clear paint_pending, frame_cnt+1, then go to FETCH with line=0. vga_base changes on the cycle after the DONE exit.

Handshake:
- paint_done is sticky: a pulse in any state sets paint_pending.
- paint_done coincident with the DONE exit is kept for the next frame.

Addressing:
- px_addr = back + ((line*CHAR_H+row)*COLUMNS+col), computed at ADDR_W bits, no wrap.
- Minimum throughput is 3 cycles per glyph row with px_ready held high.

Shading:
- Pixel i (0 = leftmost) is px_data[i*COLOR_W +: COLOR_W], taken from font_data[CHAR_W-1-i]: set → fg, clear → bg.
- invert swaps fg and bg.
- Cell blink with blink phase=1 forces all glyph bits to 0.
- The cursor cell is visible when cursor_en and (!cursor_blink or phase==0). It swaps fg and bg again, on all rows (block) or rows CHAR_H-2..CHAR_H-1 (underline).
- A cursor column or line beyond the grid gives no cursor.

Decomposition:
- text_render_pkg: cell field offsets and widths, CELL_W, render state enum, cursor style constants.
- Sub-module glyph_row_shader: combinational font row + cell + cursor flags + blink phase → px_data. Verified standalone.

Test Plan:
Bench parameters: COLUMNS=4, LINES=2, CHAR_H=4, CHAR_W=8, COLOR_W=3, BUF_B='h100.
1. Reset, all cells code 'h41 fg=7 bg=0, font row 'hF0, px_ready=1 → 32 writes at 'h100..'h11F in order; each px_data = four pixels of 7 (left) then four of 0; busy falls after the last write.
2. px_ready low 5 cycles mid-frame → px_valid, px_addr and px_data stable throughout; no write is lost or duplicated.
3. Pulse paint_done during rendering → after DONE, vga_base='h100, frame_cnt=1; next frame writes start at base 0.
4. Cursor at (col 2, line 1), underline, font row 'h00 → only addrs (1*4+2)*4+2 and (1*4+3)*4+2 (i.e. 'h11A and 'h11E) show fg=7 on all pixels.
5. Cell with blink=1 and frame_cnt[4]=1 → all pixels bg. The same cell with invert=1 → all pixels fg.
6. rst for 1 cycle mid-EMIT → px_valid=0 next cycle; vga_base=BUF_A; rendering restarts at line 0.

Source files
------------

// File: rtl/text_render_pkg.sv
`default_nettype none
// ============================================================================
// Package     : text_render_pkg
// Description : Cell field layout, render FSM states and cursor style codes
//               shared by the text grid renderer and its glyph shader.
// Revision    : 1.0 - initial release
// ============================================================================
package text_render_pkg;

  localparam int CODE_LSB = 0;
  localparam int CODE_W   = 8;
  localparam int FG_LSB   = CODE_LSB + CODE_W;

  // Remaining cell fields depend on the colour depth chosen by the top level.
  function automatic int bg_lsb(input int color_w);
    return FG_LSB + color_w;
  endfunction

  function automatic int inv_bit(input int color_w);
    return FG_LSB + 2 * color_w;
  endfunction

  function automatic int blink_bit(input int color_w);
    return FG_LSB + 2 * color_w + 1;
  endfunction

  function automatic int cell_w(input int color_w);
    return FG_LSB + 2 * color_w + 2;
  endfunction

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_LATCH = 3'd1,
    ST_FREQ  = 3'd2,
    ST_FWAIT = 3'd3,
    ST_EMIT  = 3'd4,
    ST_DONE  = 3'd5
  } render_state_t;

  localparam logic CURSOR_UNDERLINE = 1'b0;
  localparam logic CURSOR_BLOCK     = 1'b1;
  localparam int   UNDERLINE_ROWS   = 2;

endpackage
`default_nettype wire

// File: rtl/glyph_row_shader.sv
`default_nettype none
// ============================================================================
// Module      : glyph_row_shader
// Description : Combinational shading of one font row into colour pixels,
//               applying invert, cell blink and cursor overlay.
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_row_shader #(
  parameter int CHAR_W  = 8,
  parameter int COLOR_W = 3
) (
  input  logic [CHAR_W-1:0]         i_font_row,
  input  logic [COLOR_W-1:0]        i_fg,
  input  logic [COLOR_W-1:0]        i_bg,
  input  logic                      i_invert,
  input  logic                      i_blink,
  input  logic                      i_blink_phase,
  input  logic                      i_cursor_hit,
  output logic [CHAR_W*COLOR_W-1:0] o_px_data
);

  logic [CHAR_W-1:0]  w_glyph;
  logic               w_swap;
  logic [COLOR_W-1:0] w_on;
  logic [COLOR_W-1:0] w_off;

  assign w_glyph = (i_blink && i_blink_phase) ? '0 : i_font_row;
  // Cursor flips colours on top of any cell inversion.
  assign w_swap  = i_invert ^ i_cursor_hit;
  assign w_on    = w_swap ? i_bg : i_fg;
  assign w_off   = w_swap ? i_fg : i_bg;

  for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_px
    assign o_px_data[gi*COLOR_W +: COLOR_W] = w_glyph[CHAR_W-1-gi] ? w_on : w_off;
  end

endmodule
`default_nettype wire

// File: rtl/text_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module      : text_grid_renderer
// Description : Renders a LINES x COLUMNS text grid into the back half of a
//               double-buffered framebuffer and swaps with the scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module text_grid_renderer
  import text_render_pkg::*;
#(
  parameter int                COLUMNS     = 80,
  parameter int                LINES       = 30,
  parameter int                CHAR_W      = 8,
  parameter int                CHAR_H      = 16,
  parameter int                COLOR_W     = 3,
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] BUF_A       = '0,
  parameter logic [ADDR_W-1:0] BUF_B       = ADDR_W'('h40000),
  parameter int                BLINK_SHIFT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_paint_done,
  output logic [$clog2(LINES)-1:0]             o_text_addr,
  input  logic [COLUMNS*cell_w(COLOR_W)-1:0]   i_text_data,
  output logic [8+$clog2(CHAR_H)-1:0]          o_font_addr,
  input  logic [CHAR_W-1:0]                    i_font_data,
  input  logic                                 i_cursor_en,
  input  logic                                 i_cursor_blink,
  input  logic                                 i_cursor_block,
  input  logic [$clog2(COLUMNS)-1:0]           i_cursor_col,
  input  logic [$clog2(LINES)-1:0]             i_cursor_line,
  output logic                                 o_px_valid,
  input  logic                                 i_px_ready,
  output logic [ADDR_W-1:0]                    o_px_addr,
  output logic [CHAR_W*COLOR_W-1:0]            o_px_data,
  output logic [ADDR_W-1:0]                    o_vga_base,
  output logic                                 o_busy,
  output logic [7:0]                           o_frame_cnt
);

  localparam int COL_W  = $clog2(COLUMNS);
  localparam int LINE_W = $clog2(LINES);
  localparam int ROW_W  = $clog2(CHAR_H);
  localparam int CELL_W = cell_w(COLOR_W);
  localparam int BG_LSB = bg_lsb(COLOR_W);
  localparam int INV_B  = inv_bit(COLOR_W);
  localparam int BLK_B  = blink_bit(COLOR_W);

  render_state_t               r_state;
  logic [LINE_W-1:0]           r_line;
  logic [COL_W-1:0]            r_col;
  logic [ROW_W-1:0]            r_row;
  logic                        r_front_b;
  logic                        r_paint_pending;
  logic                        r_busy;
  logic [7:0]                  r_frame_cnt;
  logic [COLUMNS*CELL_W-1:0]   r_line_word;
  logic [8+ROW_W-1:0]          r_font_addr;
  logic                        r_px_valid;
  logic [ADDR_W-1:0]           r_px_addr;
  logic [CHAR_W*COLOR_W-1:0]   r_px_data;
  logic                        r_cur_en;
  logic                        r_cur_blink;
  logic                        r_cur_block;
  logic [COL_W-1:0]            r_cur_col;
  logic [LINE_W-1:0]           r_cur_line;

  logic [CELL_W-1:0]           w_cells [COLUMNS];
  logic                        w_last_row;
  logic                        w_last_col;
  logic                        w_last_line;
  logic [ROW_W-1:0]            w_next_row;
  logic [COL_W-1:0]            w_next_col;
  logic [ADDR_W-1:0]           w_back;
  logic [ADDR_W-1:0]           w_offset;
  logic                        w_phase;
  logic                        w_cursor_hit;
  logic [CHAR_W*COLOR_W-1:0]   w_px_data;

  for (genvar gi = 0; gi < COLUMNS; gi++) begin : g_cells
    assign w_cells[gi] = r_line_word[gi*CELL_W +: CELL_W];
  end

  assign w_last_row  = (r_row  == ROW_W'(CHAR_H - 1));
  assign w_last_col  = (r_col  == COL_W'(COLUMNS - 1));
  assign w_last_line = (r_line == LINE_W'(LINES - 1));
  assign w_next_row  = w_last_row ? '0 : r_row + 1'b1;
  assign w_next_col  = w_last_row ? (w_last_col ? '0 : r_col + 1'b1) : r_col;

  assign w_back   = r_front_b ? BUF_A : BUF_B;
  assign w_offset = ((ADDR_W'(r_line) * ADDR_W'(CHAR_H) + ADDR_W'(r_row))
                    * ADDR_W'(COLUMNS)) + ADDR_W'(r_col);
  assign w_phase  = r_frame_cnt[BLINK_SHIFT];

  // Out-of-grid cursor coordinates can never equal a live col/line.
  assign w_cursor_hit = r_cur_en && (!r_cur_blink || !w_phase)
                     && (r_cur_col == r_col) && (r_cur_line == r_line)
                     && ((r_cur_block == CURSOR_BLOCK) ||
                         ((r_cur_block == CURSOR_UNDERLINE) &&
                          (r_row >= ROW_W'(CHAR_H - UNDERLINE_ROWS))));

  glyph_row_shader #(
    .CHAR_W  (CHAR_W),
    .COLOR_W (COLOR_W)
  ) u_shader (
    .i_font_row    (i_font_data),
    .i_fg          (w_cells[r_col][FG_LSB +: COLOR_W]),
    .i_bg          (w_cells[r_col][BG_LSB +: COLOR_W]),
    .i_invert      (w_cells[r_col][INV_B]),
    .i_blink       (w_cells[r_col][BLK_B]),
    .i_blink_phase (w_phase),
    .i_cursor_hit  (w_cursor_hit),
    .o_px_data     (w_px_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_FETCH;
      r_line          <= '0;
      r_col           <= '0;
      r_row           <= '0;
      r_front_b       <= 1'b0;
      r_paint_pending <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_cnt     <= '0;
      r_line_word     <= '0;
      r_font_addr     <= '0;
      r_px_valid      <= 1'b0;
      r_px_addr       <= '0;
      r_px_data       <= '0;
      r_cur_en        <= 1'b0;
      r_cur_blink     <= 1'b0;
      r_cur_block     <= 1'b0;
      r_cur_col       <= '0;
      r_cur_line      <= '0;
    end else begin
      if (i_paint_done)
        r_paint_pending <= 1'b1;

      case (r_state)
        ST_FETCH: begin
          if (r_line == '0) begin
            r_cur_en    <= i_cursor_en;
            r_cur_blink <= i_cursor_blink;
            r_cur_block <= i_cursor_block;
            r_cur_col   <= i_cursor_col;
            r_cur_line  <= i_cursor_line;
            r_busy      <= 1'b1;
          end
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_line_word <= i_text_data;
          // A new line always starts at column 0, row 0.
          r_font_addr <= {i_text_data[CODE_LSB +: CODE_W], r_row};
          r_state     <= ST_FREQ;
        end
        ST_FREQ: begin
          r_state <= ST_FWAIT;
        end
        ST_FWAIT: begin
          r_px_addr  <= w_back + w_offset;
          r_px_data  <= w_px_data;
          r_px_valid <= 1'b1;
          r_state    <= ST_EMIT;
        end
        ST_EMIT: begin
          if (i_px_ready) begin
            r_px_valid  <= 1'b0;
            r_row       <= w_next_row;
            r_col       <= w_next_col;
            r_font_addr <= {w_cells[w_next_col][CODE_LSB +: CODE_W], w_next_row};
            if (!(w_last_row && w_last_col)) begin
              r_state <= ST_FREQ;
            end else if (!w_last_line) begin
              r_line  <= r_line + 1'b1;
              r_state <= ST_FETCH;
            end else begin
              r_line  <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (r_paint_pending) begin
            r_front_b       <= ~r_front_b;
            r_paint_pending <= i_paint_done;
            r_frame_cnt     <= r_frame_cnt + 8'd1;
            r_state         <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign o_text_addr = r_line;
  assign o_font_addr = r_font_addr;
  assign o_px_valid  = r_px_valid;
  assign o_px_addr   = r_px_addr;
  assign o_px_data   = r_px_data;
  assign o_vga_base  = r_front_b ? BUF_B : BUF_A;
  assign o_busy      = r_busy;
  assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
